// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//
// Instruction fetch unit with a small prefetch queue. A three-state FSM issues
// one instruction-memory read at a time, pushes each returned word (tagged
// with the address it was fetched from) into a circular buffer, and pulses the
// PC register's enable once per accepted word. A branch/redirect flushes the
// queue, pulses the PC enable so the PC register loads the branch target, and
// turns any in-flight read into a discarded "drain" read.
//
// Optional feature: define FETCH_QUEUE_BYPASS_EN to forward an acknowledged
// word straight to decode in the acknowledge cycle when the queue is empty and
// decode is ready. Without it, there is no combinational path from the memory
// response to the decode outputs (one cycle minimum latency).
//
// Parameters
//   ADDR_W   fetch address / PC width
//   INSTR_W  instruction word width
//   DEPTH    queue entries (power of two, >= 2)
//
// Ports
//   clk         clock, rising edge
//   rst         asynchronous reset, active low
//   pc          current PC register value
//   pcEn        PC register load enable (PC+4, or branch target when
//               branchFlag is high)
//   branchFlag  redirect / flush request
//   memReq      instruction memory read request
//   memAddr     instruction memory read address
//   memAck      one-cycle read acknowledge, memData valid in that cycle
//   memData     instruction memory read data
//   instrValid  queue head valid toward decode
//   instr       head instruction
//   instrPc     address of the head instruction
//   instrReady  decode accepts the head this cycle
// -----------------------------------------------------------------------------
module fetch_queue #(
  parameter int ADDR_W  = 24,
  parameter int INSTR_W = 32,
  parameter int DEPTH   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  pc,
  output logic               pcEn,
  input  logic               branchFlag,
  output logic               memReq,
  output logic [ADDR_W-1:0]  memAddr,
  input  logic               memAck,
  input  logic [INSTR_W-1:0] memData,
  output logic               instrValid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instrPc,
  input  logic               instrReady
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;

  // Goes high on the first rising edge after reset release; keeps the first
  // request from being presented before that edge.
  logic               live;
  logic [ADDR_W-1:0]  pc_lat;

  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   count;
  logic [INSTR_W-1:0] data_mem [DEPTH];
  logic [ADDR_W-1:0]  pc_mem   [DEPTH];

  logic               full;
  logic               empty;
  logic               issue;
  logic               accept;
  logic               push;
  logic               pop;
  logic               req_c;
  logic               pc_en_c;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      live  <= 1'b0;
    end else begin
      state <= state_nxt;
      live  <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and request/enable outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    req_c     = 1'b0;
    pc_en_c   = 1'b0;
    issue     = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (branchFlag) begin
          pc_en_c = 1'b1;
        end else if (live && !full) begin
          // The slot for this word is reserved now: count can only fall
          // while the read is outstanding, so the later push cannot overflow.
          req_c     = 1'b1;
          issue     = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        req_c = 1'b1;
        if (branchFlag) begin
          pc_en_c   = 1'b1;
          state_nxt = memAck ? IDLE : DRAIN;
        end else if (memAck) begin
          pc_en_c   = 1'b1;
          accept    = 1'b1;
          state_nxt = IDLE;
        end
      end
      DRAIN: begin
        // The stale read is still outstanding; keep requesting until it
        // completes, even across further redirects, so only one read is
        // ever in flight and its data is never mistaken for a new fetch.
        req_c = 1'b1;
        if (branchFlag) begin
          pc_en_c = 1'b1;
        end
        if (memAck) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State is already IDLE during reset and live is low, so memReq is quiet;
  // pcEn needs the explicit gate because branchFlag may toggle in reset.
  assign memReq  = req_c;
  assign pcEn    = pc_en_c & rst;
  assign memAddr = !req_c ? '0 : ((state == IDLE) ? pc : pc_lat);

  // ---------------------------------------------------------------------------
  // Latched fetch address
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_lat <= '0;
    end else if (issue) begin
      pc_lat <= pc;
    end
  end

  // ---------------------------------------------------------------------------
  // Decode-side outputs and push/pop qualification
  // ---------------------------------------------------------------------------
`ifdef FETCH_QUEUE_BYPASS_EN
  logic bypass;

  assign bypass     = accept && empty && instrReady;
  assign push       = accept && !bypass;
  assign pop        = !empty && instrReady;
  assign instrValid = !empty || bypass;
  assign instr      = bypass ? memData :
                      (empty ? '0 : data_mem[rd_ptr]);
  assign instrPc    = bypass ? pc_lat :
                      (empty ? '0 : pc_mem[rd_ptr]);
`else
  assign push       = accept;
  assign pop        = !empty && instrReady;
  assign instrValid = !empty;
  assign instr      = empty ? '0 : data_mem[rd_ptr];
  assign instrPc    = empty ? '0 : pc_mem[rd_ptr];
`endif

  // ---------------------------------------------------------------------------
  // Queue control: pointers wrap naturally at PTR_W bits (DEPTH is 2^PTR_W)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (branchFlag) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Queue storage: data only, never reset (outputs are masked when empty)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr] <= memData;
      pc_mem[wr_ptr]   <= pc_lat;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_fetch_queue
//
// Bench for fetch_queue. A cycle-based model plays the instruction memory
// (fixed ack latency) and the PC register, predicts memReq/memAddr/pcEn each
// cycle, and keeps a scoreboard of words expected at the decode port. A table
// of fetch scenarios runs first, then hand-written redirect, full-queue and
// reset sequences.
// -----------------------------------------------------------------------------
module tb_fetch_queue;

  localparam int ADDR_W  = 24;
  localparam int INSTR_W = 32;
  localparam int DEPTH   = 4;

  logic               clk;
  logic               rst;
  logic [ADDR_W-1:0]  pc;
  logic               pcEn;
  logic               branchFlag;
  logic               memReq;
  logic [ADDR_W-1:0]  memAddr;
  logic               memAck;
  logic [INSTR_W-1:0] memData;
  logic               instrValid;
  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  instrPc;
  logic               instrReady;

  fetch_queue #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W),
    .DEPTH   (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pc         (pc),
    .pcEn       (pcEn),
    .branchFlag (branchFlag),
    .memReq     (memReq),
    .memAddr    (memAddr),
    .memAck     (memAck),
    .memData    (memData),
    .instrValid (instrValid),
    .instr      (instr),
    .instrPc    (instrPc),
    .instrReady (instrReady)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0]  addr;
    logic [INSTR_W-1:0] data;
  } ent_t;

  typedef struct {
    int                lat;
    logic [7:0]        rdy;
    logic [ADDR_W-1:0] pc0;
    int                k;
    logic [ADDR_W-1:0] exp_last;
  } vec_t;

  ent_t sb[$];
  int   tests;
  int   fails;

  // memory / PC register model
  bit                outst;
  bit                cancel;
  int                cnt;
  int                lat;
  logic [ADDR_W-1:0] addr_o;
  logic [ADDR_W-1:0] pc_m;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] last_pc;
  int                pops;
  int                pcen_cnt;

  // last sampled outputs
  logic              s_memReq;
  logic [ADDR_W-1:0] s_memAddr;
  logic              s_pcEn;
  logic              s_instrValid;
  logic [ADDR_W-1:0] s_instrPc;

  function automatic logic [INSTR_W-1:0] mkdata(input logic [ADDR_W-1:0] a);
    return {a[7:0] ^ 8'h5A, a};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_memReq"},     {31'd0, memReq},     32'd0);
    chk({tag, "_pcEn"},       {31'd0, pcEn},       32'd0);
    chk({tag, "_instrValid"}, {31'd0, instrValid}, 32'd0);
    chk({tag, "_memAddr"},    {8'd0, memAddr},     32'd0);
    chk({tag, "_instr"},      instr,               32'd0);
    chk({tag, "_instrPc"},    {8'd0, instrPc},     32'd0);
  endtask

  task automatic model_clear();
    sb.delete();
    outst    = 1'b0;
    cancel   = 1'b0;
    cnt      = 0;
    pops     = 0;
    pcen_cnt = 0;
  endtask

  // Release reset at a falling edge; optionally present a stale ack pulse,
  // which the DUT must ignore while it has nothing outstanding.
  task automatic release_rst(input bit stale);
    @(negedge clk);
    rst    = 1'b1;
    memAck = stale;
    #1;
    chk("rel_memReq", {31'd0, memReq}, 32'd0);
    chk("rel_pcEn",   {31'd0, pcEn},   32'd0);
  endtask

  task automatic do_reset(input logic [ADDR_W-1:0] pc0);
    @(negedge clk);
    rst        = 1'b0;
    memAck     = 1'b0;
    branchFlag = 1'b0;
    instrReady = 1'b0;
    #1;
    chk_all_zero("rst");
    model_clear();
    pc_m = pc0;
    pc   = pc0;
    @(negedge clk);
    release_rst(1'b0);
  endtask

  // One clock cycle: drive inputs at the falling edge, sample and predict.
  task automatic step(input bit br, input bit rdy);
    bit   ack;
    bit   was_out;
    bit   exp_req;
    bit   exp_pcen;
    bit   accept;
    bit   exp_vld;
    ent_t e;
    @(negedge clk);
    pc  = pc_m;
    ack = 1'b0;
    if (outst) begin
      cnt--;
      ack = (cnt == 0);
    end
    memAck     = ack;
    memData    = ack ? mkdata(addr_o) : INSTR_W'($urandom);
    branchFlag = br;
    instrReady = rdy;
    #1;
    s_memReq     = memReq;
    s_memAddr    = memAddr;
    s_pcEn       = pcEn;
    s_instrValid = instrValid;
    s_instrPc    = instrPc;

    was_out = outst;
    exp_req = outst || ((sb.size() < DEPTH) && !br);
    chk("memReq", {31'd0, memReq}, {31'd0, exp_req});
    if (exp_req) chk("memAddr", {8'd0, memAddr}, {8'd0, (outst ? addr_o : pc_m)});
    exp_pcen = br || (ack && !cancel);
    chk("pcEn", {31'd0, pcEn}, {31'd0, exp_pcen});

    accept = ack && !cancel && !br;
`ifdef FETCH_QUEUE_BYPASS_EN
    if (accept && (sb.size() == 0) && rdy) begin
      e.addr = addr_o;
      e.data = mkdata(addr_o);
      sb.push_back(e);
      accept = 1'b0;
    end
`endif
    exp_vld = (sb.size() != 0);
    chk("instrValid", {31'd0, instrValid}, {31'd0, exp_vld});
    if (exp_vld) begin
      chk("instr",   instr,            sb[0].data);
      chk("instrPc", {8'd0, instrPc},  {8'd0, sb[0].addr});
      if (rdy) begin
        last_pc = sb[0].addr;
        void'(sb.pop_front());
        pops++;
      end
    end
    if (accept) begin
      e.addr = addr_o;
      e.data = mkdata(addr_o);
      sb.push_back(e);
    end
    if (br) sb.delete();

    if (ack) begin
      outst  = 1'b0;
      cancel = 1'b0;
    end else if (br && was_out) begin
      cancel = 1'b1;
    end
    if (!was_out && exp_req) begin
      outst  = 1'b1;
      cnt    = lat;
      addr_o = pc_m;
      cancel = 1'b0;
    end
    if (exp_pcen) pc_m = br ? target : pc_m + 24'd4;
    if (pcEn) pcen_cnt++;
  endtask

  vec_t vt[5];

  initial begin
    int n;
    tests      = 0;
    fails      = 0;
    rst        = 1'b0;
    pc         = '0;
    branchFlag = 1'b0;
    memAck     = 1'b0;
    memData    = '0;
    instrReady = 1'b0;
    target     = '0;
    last_pc    = '0;
    lat        = 2;
    model_clear();

    //        lat  rdy     pc0          k   last instrPc
    vt[0] = '{2,  8'hFF, 24'h000000,  3, 24'h000008};
    vt[1] = '{1,  8'hFF, 24'h000100,  8, 24'h00011C};
    vt[2] = '{4,  8'h55, 24'hFFFFF8,  4, 24'h000004};
    vt[3] = '{1,  8'h11, 24'h000040, 10, 24'h000064};
    vt[4] = '{3,  8'h0F, 24'h002000,  5, 24'h002010};

    repeat (2) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      lat = vt[i].lat;
      do_reset(vt[i].pc0);
      n = 0;
      while (pops < vt[i].k && n < 400) begin
        step(1'b0, vt[i].rdy[n % 8]);
        n++;
      end
      chk("vec_pops",    pops,              vt[i].k);
      chk("vec_last_pc", {8'd0, last_pc},   {8'd0, vt[i].exp_last});
    end

    // Decode stalled: queue fills to DEPTH, then requests stop.
    lat = 1;
    do_reset(24'h000000);
    n = 0;
    while (sb.size() < DEPTH && n < 100) begin
      step(1'b0, 1'b0);
      n++;
    end
    chk("full_size", sb.size(), DEPTH);
    chk("full_pcen", pcen_cnt, 4);
    for (int j = 0; j < 3; j++) begin
      step(1'b0, 1'b0);
      chk("full_noreq", {31'd0, s_memReq}, 32'd0);
    end
    step(1'b0, 1'b1);
    chk("full_pop_pc", {8'd0, s_instrPc}, 32'h0);
    step(1'b0, 1'b0);
    chk("refill_req",  {31'd0, s_memReq}, 32'd1);
    chk("refill_addr", {8'd0, s_memAddr}, 32'h000010);

    // Redirect while a read is pending; its late ack must be dropped.
    lat = 1;
    do_reset(24'h000010);
    n = 0;
    while (sb.size() < 2 && n < 100) begin
      step(1'b0, 1'b0);
      n++;
    end
    chk("pre_fill", sb.size(), 2);
    lat = 4;
    step(1'b0, 1'b0);
    chk("br_issue", {31'd0, s_memReq}, 32'd1);
    target = 24'h000100;
    pcen_cnt = 0;
    step(1'b1, 1'b0);
    chk("br_pcen", {31'd0, s_pcEn}, 32'd1);
    step(1'b0, 1'b0);
    chk("br_flushed", {31'd0, s_instrValid}, 32'd0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk("drain_ack_pcen", {31'd0, s_pcEn}, 32'd0);
    chk("drain_pcen_cnt", pcen_cnt, 1);
    step(1'b0, 1'b0);
    chk("br_new_req",  {31'd0, s_memReq}, 32'd1);
    chk("br_new_addr", {8'd0, s_memAddr}, 32'h000100);
    chk("br_empty",    {31'd0, s_instrValid}, 32'd0);

    // Redirect in the same cycle as the ack.
    lat = 2;
    do_reset(24'h000300);
    target = 24'h000180;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    chk("brack_pcen", {31'd0, s_pcEn}, 32'd1);
    step(1'b0, 1'b0);
    chk("brack_vld",  {31'd0, s_instrValid}, 32'd0);
    chk("brack_req",  {31'd0, s_memReq}, 32'd1);
    chk("brack_addr", {8'd0, s_memAddr}, 32'h000180);
    chk("brack_cnt",  pcen_cnt, 1);

    // Reset in the middle of a pending read.
    lat = 6;
    do_reset(24'h000040);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk_all_zero("async");
    model_clear();
    @(negedge clk);
    release_rst(1'b1);
    lat = 2;
    step(1'b0, 1'b1);
    chk("restart_req",  {31'd0, s_memReq}, 32'd1);
    chk("restart_addr", {8'd0, s_memAddr}, 32'h000040);
    n = 0;
    while (pops < 1 && n < 50) begin
      step(1'b0, 1'b1);
      n++;
    end
    chk("restart_pop", {8'd0, last_pc}, 32'h000040);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter ADDR_W, default 24: fetch-address width, equal to the PC width.
REQ-002 Parameter INSTR_W, default 32: instruction word width.
REQ-003 Parameter DEPTH, default 4: queue entries; a power of two, at least 2.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst  in  1  reset, asynchronous and active-low.
REQ-006 pc  in  ADDR_W  current fetch address from the PC register.
REQ-007 pcEn  out  1  enable to the PC register; when high, the PC register loads PC+4, or the branch target if branchFlag is high.
REQ-008 branchFlag  in  1  redirect/flush request; the same signal selects the branch target in the PC register.
REQ-009 memReq  out  1  instruction-memory read request.
REQ-010 memAddr  out  ADDR_W  read address.
REQ-011 memAck  in  1  one-cycle pulse; memData valid in that cycle.
REQ-012 memData  in  INSTR_W  read data.
REQ-013 instrValid  out  1  queue head valid toward decode.
REQ-014 instr  out  INSTR_W  head instruction.
REQ-015 instrPc  out  ADDR_W  address of the head instruction.
REQ-016 instrReady  in  1  decode accepts the head; a pop occurs when instrValid and instrReady are both high.

Function
REQ-017 The FSM SHALL have three states: IDLE, WAIT and DRAIN.
REQ-018 IDLE, with count < DEPTH and branchFlag low: assert memReq with memAddr=pc, latch pc, go to WAIT.
REQ-019 IDLE, queue full: keep memReq low and stay in IDLE.
REQ-020 WAIT: hold memReq high and memAddr stable (latched pc) until memAck.
REQ-021 WAIT, memAck with branchFlag low: push {latched pc, memData}, pulse pcEn for exactly one cycle, go to IDLE.
REQ-022 branchFlag high in any state: flush all entries (count=0, instrValid=0 next cycle), assert pcEn in that cycle.
REQ-023 Next state on branchFlag: WAIT without memAck goes to DRAIN; otherwise IDLE. Any memAck in that cycle is discarded.
REQ-024 DRAIN: hold memReq high until memAck, discard the data, assert no pcEn, then go to IDLE.
REQ-025 At most one memory request SHALL be outstanding.
REQ-026 A slot is reserved when a request is issued (count < DEPTH at issue), so a push can never overflow.
REQ-027 Queue: circular buffer, log2(DEPTH)-bit read/write pointers wrapping modulo DEPTH, count 0..DEPTH.
REQ-028 A simultaneous push and pop SHALL leave count unchanged.
REQ-029 A pop on an empty queue SHALL have no effect.
REQ-030 Without bypass, minimum latency from memAck to instrValid is 1 cycle.

Reset
REQ-031 While rst=0: FSM=IDLE; pointers and count are 0; latched pc is 0.
REQ-032 While rst=0: memReq=0, pcEn=0, instrValid=0, memAddr=0, instr=0, instrPc=0.
REQ-033 Reset asserted mid-WAIT SHALL abandon the request; a memAck arriving after reset release while in IDLE is ignored.
REQ-034 The first request SHALL be issued no earlier than the first rising edge after rst deasserts.

Configuration
REQ-035 FETCH_QUEUE_BYPASS_EN defined: with the queue empty, a WAIT memAck, instrReady high and branchFlag low, memData/latched pc appear combinationally on instr/instrPc with instrValid=1 in the memAck cycle, and nothing is pushed.
REQ-036 FETCH_QUEUE_BYPASS_EN undefined: no combinational path exists from memAck/memData to instrValid/instr; the REQ-030 latency applies.

Verification
REQ-037 Reset release, pc=0x000000, memAck 2 cycles after each memReq, instrReady=1 -> memAddr sequence 0x0,0x4,0x8; one pcEn pulse per memAck; instrPc follows the same sequence.
REQ-038 instrReady=0, DEPTH=4 -> exactly 4 pushes, count=4, memReq stays 0; raising instrReady for 1 cycle -> one pop, then a new request next cycle.
REQ-039 branchFlag pulse in WAIT with pc target 0x000100, then memAck 3 cycles later -> flush (instrValid=0), pcEn=1 in the branch cycle, acked data discarded, next memAddr=0x000100.
REQ-040 branchFlag coincident with memAck -> data not pushed, state IDLE next cycle, pcEn=1 exactly once.
REQ-041 rst pulled low mid-WAIT -> all outputs 0 asynchronously; after release, fetch restarts at the current pc.
REQ-042 Push and pop in the same cycle at count=2 -> count stays 2; after 8 pushes (2 full laps) pointers wrap and head order is preserved.
